// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone bus arbiter with a per-tenure watchdog that raises a
// one-cycle timeout error when the granted master strobes without response.
module wb_arbiter_rr #(
   parameter int MASTERS_NUM    = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [MASTERS_NUM-1:0]         m_cyc_i,
   input  logic [MASTERS_NUM-1:0]         m_stb_i,
   input  logic                           s_ack_i,
   input  logic                           s_err_i,
   output logic [MASTERS_NUM-1:0]         gnt_o,
   output logic [$clog2(MASTERS_NUM)-1:0] gnt_idx_o,
   output logic                           gnt_valid_o,
   output logic                           cyc_o,
   output logic                           stb_o,
   output logic                           tmo_err_o,
   output logic [1:0]                     state_o
);

   localparam int IW = $clog2(MASTERS_NUM);
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TMO   = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [MASTERS_NUM-1:0] gnt_q, gnt_d;
   logic [IW-1:0]          gnt_idx_q, gnt_idx_d;
   logic [IW-1:0]          last_gnt_q, last_gnt_d;
   logic [7:0]             wdog_q, wdog_d;
   logic                   tmo_err_q, tmo_err_d;
   logic [IW-1:0]          sel_idx;
   logic                   sel_found;
   logic                   cyc_gnt;

   // Bus handshake: a transfer is offered while cyc_o && stb_o are high and
   // completes in any cycle where s_ack_i or s_err_i is high; the watchdog
   // only counts offered cycles that complete neither way.
   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign gnt_valid_o = $onehot(gnt_q);
   assign cyc_gnt     = |(m_cyc_i & gnt_q);
   assign cyc_o       = cyc_gnt & gnt_valid_o;
   assign stb_o       = (|(m_stb_i & gnt_q)) & gnt_valid_o;
   assign tmo_err_o   = tmo_err_q;
   assign state_o     = state_q;

   // Search upward from the master after the last one granted, wrapping.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 1; i <= MASTERS_NUM; i++) begin
         int cand;
         cand = int'(last_gnt_q) + i;
         if (cand >= MASTERS_NUM) cand = cand - MASTERS_NUM;
         if (!sel_found && m_cyc_i[cand]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(cand);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_idx_d  = gnt_idx_q;
      last_gnt_d = last_gnt_q;
      wdog_d     = wdog_q;
      tmo_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (sel_found) begin
               state_d    = GRANT;
               gnt_d      = MASTERS_NUM'(1) << sel_idx;
               gnt_idx_d  = sel_idx;
               last_gnt_d = sel_idx;
            end
         end
         GRANT: begin
            if (!cyc_gnt) begin
               state_d   = IDLE;
               gnt_d     = '0;
               gnt_idx_d = '0;
               wdog_d    = '0;
            end else if (!stb_o || s_ack_i || s_err_i) begin
               wdog_d = '0;
            end else if (wdog_q == WD_LIMIT) begin
               state_d   = TMO;
               tmo_err_d = 1'b1;
               wdog_d    = '0;
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
         end
         TMO: begin
            wdog_d = '0;
            if (cyc_gnt) begin
               state_d = GRANT;
            end else begin
               state_d   = IDLE;
               gnt_d     = '0;
               gnt_idx_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
            wdog_d    = '0;
         end
      endcase
   end

   // last_gnt resets to the top master so master 0 wins the first search.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gnt_idx_q  <= '0;
         last_gnt_q <= IW'(MASTERS_NUM - 1);
         wdog_q     <= '0;
         tmo_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         last_gnt_q <= last_gnt_d;
         wdog_q     <= wdog_d;
         tmo_err_q  <= tmo_err_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: directed scenarios plus randomized traffic, all
// compared against a tenure-level reference model of the arbiter.
module tb_wb_arbiter_rr;

   localparam int N   = 3;
   localparam int TMO = 16;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [N-1:0] m_cyc_i;
   logic [N-1:0] m_stb_i;
   logic         s_ack_i;
   logic         s_err_i;
   logic [N-1:0] gnt_o;
   logic [1:0]   gnt_idx_o;
   logic         gnt_valid_o;
   logic         cyc_o;
   logic         stb_o;
   logic         tmo_err_o;
   logic [1:0]   state_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: who owns the bus, who owned it last, how many
   // consecutive unanswered strobe cycles, and whether this is a timeout cycle.
   int m_owner;
   int m_last;
   int m_unacked;
   bit m_tmo;

   wb_arbiter_rr #(.MASTERS_NUM(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .m_cyc_i     (m_cyc_i),
      .m_stb_i     (m_stb_i),
      .s_ack_i     (s_ack_i),
      .s_err_i     (s_err_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_valid_o (gnt_valid_o),
      .cyc_o       (cyc_o),
      .stb_o       (stb_o),
      .tmo_err_o   (tmo_err_o),
      .state_o     (state_o)
   );

   // ---------------- clock / reset ----------------
   always #10 clk_i = ~clk_i;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got no end of test, expected end before time limit");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner   = -1;
      m_last    = N - 1;
      m_unacked = 0;
      m_tmo     = 1'b0;
   endtask

   task automatic model_step();
      bit found;
      int c;
      if (rst_i) begin
         model_reset();
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && m_cyc_i[c]) begin
               found     = 1'b1;
               m_owner   = c;
               m_last    = c;
               m_unacked = 0;
            end
         end
      end else if (m_tmo) begin
         m_tmo     = 1'b0;
         m_unacked = 0;
         if (!m_cyc_i[m_owner]) m_owner = -1;
      end else if (!m_cyc_i[m_owner]) begin
         m_owner   = -1;
         m_unacked = 0;
      end else if (m_stb_i[m_owner] && !s_ack_i && !s_err_i) begin
         m_unacked++;
         if (m_unacked == TMO) begin
            m_tmo     = 1'b1;
            m_unacked = 0;
         end
      end else begin
         m_unacked = 0;
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] exp_gnt;
      logic         own;
      own     = (m_owner >= 0);
      exp_gnt = own ? N'(1 << m_owner) : '0;
      check_eq("gnt",       32'(gnt_o),       32'(exp_gnt));
      check_eq("gnt_idx",   32'(gnt_idx_o),   own ? 32'(m_owner) : 32'd0);
      check_eq("gnt_valid", 32'(gnt_valid_o), 32'(own));
      check_eq("tmo_err",   32'(tmo_err_o),   32'(m_tmo));
      check_eq("cyc_o",     32'(cyc_o),       own ? 32'(m_cyc_i[m_owner]) : 32'd0);
      check_eq("stb_o",     32'(stb_o),       own ? 32'(m_stb_i[m_owner]) : 32'd0);
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge; returns just after the next one.
   task automatic step(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                       input logic ack, input logic err);
      m_cyc_i = cyc;
      m_stb_i = stb;
      s_ack_i = ack;
      s_err_i = err;
      #1;
      check_outputs();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
   endtask

   // Reset pulse placed wholly between clock edges.
   task automatic async_reset_pulse();
      #2;
      rst_i = 1'b1;
      #1;
      check_eq("rst_async_gnt",   32'(gnt_o),       32'd0);
      check_eq("rst_async_valid", 32'(gnt_valid_o), 32'd0);
      check_eq("rst_async_idx",   32'(gnt_idx_o),   32'd0);
      check_eq("rst_async_tmo",   32'(tmo_err_o),   32'd0);
      check_eq("rst_async_cyc",   32'(cyc_o),       32'd0);
      #1;
      rst_i = 1'b0;
      model_reset();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int first_tmo;
      int tmo_hits;
      logic [N-1:0] cyc_r;
      logic [N-1:0] stb_r;

      rst_i   = 1'b1;
      m_cyc_i = '0;
      m_stb_i = '0;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_i);
      #1;
      check_outputs();
      check_eq("reset_gnt", 32'(gnt_o), 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Round robin with everyone requesting.
      step(3'b000, 3'b000, 0, 0);
      step(3'b111, 3'b000, 0, 0);
      check_eq("rr_first_m0", 32'(gnt_o), 32'b001);
      step(3'b111, 3'b000, 0, 0);
      step(3'b110, 3'b000, 0, 0);
      check_eq("rr_dead_cycle", 32'(gnt_o), 32'b000);
      step(3'b110, 3'b000, 0, 0);
      check_eq("rr_then_m1", 32'(gnt_o), 32'b010);
      step(3'b110, 3'b000, 0, 0);
      step(3'b101, 3'b000, 0, 0);
      step(3'b101, 3'b000, 0, 0);
      check_eq("rr_then_m2", 32'(gnt_o), 32'b100);

      // No preemption while master 2 holds the bus.
      repeat (3) step(3'b101, 3'b000, 0, 0);
      check_eq("no_preempt", 32'(gnt_o), 32'b100);
      step(3'b001, 3'b000, 0, 0);
      step(3'b001, 3'b000, 0, 0);
      check_eq("rr_wrap_m0", 32'(gnt_o), 32'b001);

      // Master 1 strobes with no response: timeout after 16 strobe cycles.
      step(3'b000, 3'b000, 0, 0);
      step(3'b010, 3'b010, 0, 0);
      first_tmo = 0;
      for (int k = 1; k <= 20; k++) begin
         if (tmo_err_o && first_tmo == 0) first_tmo = k;
         step(3'b010, 3'b010, 0, 0);
      end
      check_eq("tmo_cycle", 32'(first_tmo), 32'd17);
      check_eq("tmo_keeps_gnt", 32'(gnt_o), 32'b010);

      // Fresh tenure: ack on the 16th strobe cycle suppresses the timeout.
      step(3'b000, 3'b000, 0, 0);
      step(3'b010, 3'b010, 0, 0);
      tmo_hits = 0;
      for (int k = 1; k <= 16; k++) begin
         if (tmo_err_o) tmo_hits++;
         step(3'b010, 3'b010, (k == 16), 0);
      end
      if (tmo_err_o) tmo_hits++;
      check_eq("ack_wins", 32'(tmo_hits), 32'd0);

      // A strobe gap restarts the count.
      for (int k = 1; k <= 10; k++) begin
         if (tmo_err_o) tmo_hits++;
         step(3'b010, 3'b010, 0, 0);
      end
      step(3'b010, 3'b000, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         if (tmo_err_o) tmo_hits++;
         step(3'b010, 3'b010, 0, 0);
      end
      check_eq("gap_restart", 32'(tmo_hits), 32'd0);
      check_eq("tmo_after_gap", 32'(tmo_err_o), 32'd1);
      step(3'b010, 3'b010, 0, 0);

      // Error response also resets the watchdog and does not end the tenure.
      step(3'b010, 3'b010, 0, 1);
      check_eq("err_keeps_gnt", 32'(gnt_o), 32'b010);

      // Asynchronous reset mid-tenure, then arbitration restarts at master 0's turn.
      step(3'b000, 3'b000, 0, 0);
      step(3'b100, 3'b000, 0, 0);
      step(3'b100, 3'b100, 0, 0);
      check_eq("pre_rst_gnt", 32'(gnt_o), 32'b100);
      async_reset_pulse();
      step(3'b110, 3'b000, 0, 0);
      check_eq("post_rst_gnt", 32'(gnt_o), 32'b010);
      step(3'b000, 3'b000, 0, 0);

      // Randomized traffic with sticky requests so timeouts occur.
      cyc_r = '0;
      for (int cyc_n = 0; cyc_n < 1500; cyc_n++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 23) == 0) cyc_r[b] = ~cyc_r[b];
            stb_r[b] = ($urandom_range(0, 99) < 85);
         end
         if ($urandom_range(0, 299) == 0) async_reset_pulse();
         step(cyc_r, stb_r, ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
